slave_axis_input: RTL and testbench
===================================

// Module: slave_axis_input
// PURPOSE
//  AXI4-Stream slave front end of the target-detection pipeline, receiving the other end of the MasterOutput stream.
//  Accepts pixel/band words from the DMA, buffers them in a small circular FIFO and issues them to the
//  datapath as DATA_OUT/DATA_OUT_VALID. Honours the pipeline STALL and checks frame length against TLAST.
// PARAMETERS
//  DATA_WIDTH  32   width of TDATA and DATA_OUT
//  DEPTH       16   FIFO entries; power of 2, >=4
//  FRAME_LEN   100  words per frame; TLAST expected on word FRAME_LEN-1
// PORTS
//  CLK            in   1              clock, all logic on rising edge
//  RESETN         in   1              synchronous, active-low reset
//  S_AXIS_TDATA   in   DATA_WIDTH     stream data
//  S_AXIS_TVALID  in   1              stream valid
//  S_AXIS_TLAST   in   1              last word of frame
//  S_AXIS_TREADY  out  1              slave ready
//  STALL          in   1              datapath stall (1 = do not issue)
//  DATA_OUT       out  DATA_WIDTH     word to datapath
//  DATA_OUT_VALID out  1              DATA_OUT valid, one-cycle qualifier per word
//  LAST_OUT       out  1              DATA_OUT is the frame's last word, qualified by DATA_OUT_VALID
//  FRAME_ERR      out  1              sticky: TLAST position != FRAME_LEN-1
//  OCCUPANCY      out  $clog2(DEPTH)+1  words currently held in the FIFO
// BEHAVIOUR
//  Reset (RESETN=0 at edge): wr_ptr=rd_ptr=count=0, word_cnt=0; DATA_OUT=0, DATA_OUT_VALID=0, LAST_OUT=0,
//   FRAME_ERR=0. S_AXIS_TREADY=0 while RESETN=0. A reset mid-frame discards all buffered words.
//  S_AXIS_TREADY = RESETN && (count < DEPTH); combinational from the registered count only, with no path from TVALID.
//  Push: TVALID && TREADY at an edge stores {TLAST,TDATA} at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
//  Pop: count != 0 && STALL == 0 at an edge loads DATA_OUT/LAST_OUT from rd_ptr and sets DATA_OUT_VALID=1
//   for the next cycle; otherwise DATA_OUT_VALID=0 and DATA_OUT/LAST_OUT hold. rd_ptr wraps like wr_ptr.
//  Latency: a word accepted at edge N is popped no earlier than edge N+1 (FIFO empty, STALL=0) and is visible
//   on DATA_OUT after that edge. There is no bypass path.
//  Simultaneous push and pop: count is unchanged and both pointers advance. Push while full is impossible
//   because TREADY=0. A pop while full frees a slot, and TREADY rises the following cycle.
//  Ordering: words leave in acceptance order, and no word is duplicated or dropped under any TVALID/STALL pattern.
//  Frame check on each push (word_cnt counts accepted words, width $clog2(FRAME_LEN)+1):
//   TLAST=1 and word_cnt==FRAME_LEN-1       -> word_cnt=0, no error
//   TLAST=1 and word_cnt!=FRAME_LEN-1       -> word_cnt=0, FRAME_ERR=1 (early TLAST)
//   TLAST=0 and word_cnt==FRAME_LEN-1       -> word_cnt=0, FRAME_ERR=1 (missing TLAST)
//   otherwise                               -> word_cnt+1
//  FRAME_ERR is cleared only by reset. Data flow is never blocked by an error.
//  The block has no state machine beyond FIFO control: states are EMPTY, PARTIAL and FULL, derived from count.
//   EMPTY->PARTIAL on push with no pop; PARTIAL->FULL on a push that reaches DEPTH; FULL->PARTIAL on pop.
// STRUCTURE
//  Shared package axis_pkg: DATA_WIDTH default constant; typedef struct packed {logic last; logic [DATA_WIDTH-1:0] data;} axis_word_t.
//  Sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count) holds the storage and pointers.
//   The top level holds the TREADY logic, the output register and the frame checker.
// TESTING
//  1 Reset hold 5 cycles, TVALID=1 -> TREADY=0, DATA_OUT_VALID=0, OCCUPANCY=0; after release TREADY=1 next cycle.
//  2 Stream 0..99 back-to-back, TLAST on word 99, STALL=0 -> DATA_OUT 0..99 in order, one per cycle,
//     LAST_OUT=1 only with 99, FRAME_ERR=0.
//  3 STALL=1, stream 20 words -> 16 accepted, TREADY=0, OCCUPANCY=16. Release STALL -> all 20 emerge in order,
//     and TREADY returns to 1 one cycle after the first pop.
//  4 Random TVALID (50%) and random STALL (30%) over 1000 words -> scoreboard matches exactly, OCCUPANCY never >16.
//  5 TLAST on word 49 of a frame -> FRAME_ERR=1 from the next edge and held; the next 100-word frame still passes data.
//  6 RESETN=0 for 1 cycle with 8 words buffered mid-frame -> OCCUPANCY=0, buffered words never appear,
//     and the next frame starts with word_cnt=0 and no error.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI4-Stream input front end.
package axis_pkg;

    localparam int unsigned AXIS_DATA_WIDTH = 32;

    typedef struct packed {
        logic                       last;
        logic [AXIS_DATA_WIDTH-1:0] data;
    } axis_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with registered count; read data is the word at rd_ptr.
module sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     RESETN,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [1:0]       state;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        state = ST_PARTIAL;
        if (count == '0)
            state = ST_EMPTY;
        else if (count == (AW+1)'(DEPTH))
            state = ST_FULL;
    end

    assign full    = (state == ST_FULL);
    assign empty   = (state == ST_EMPTY);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/slave_axis_input.sv
// AXI4-Stream slave: buffers stream words, issues them to the datapath under STALL, checks frame length.
module slave_axis_input
    import axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = AXIS_DATA_WIDTH,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned FRAME_LEN  = 100
) (
    input  logic                     CLK,
    input  logic                     RESETN,
    input  logic [DATA_WIDTH-1:0]    S_AXIS_TDATA,
    input  logic                     S_AXIS_TVALID,
    input  logic                     S_AXIS_TLAST,
    output logic                     S_AXIS_TREADY,
    input  logic                     STALL,
    output logic [DATA_WIDTH-1:0]    DATA_OUT,
    output logic                     DATA_OUT_VALID,
    output logic                     LAST_OUT,
    output logic                     FRAME_ERR,
    output logic [$clog2(DEPTH):0]   OCCUPANCY
);

    localparam int unsigned CW = $clog2(FRAME_LEN) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    logic [DATA_WIDTH:0] fifo_wdata;
    logic [DATA_WIDTH:0] fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic [CW-1:0]       word_cnt;
    logic                at_last_idx;

    assign S_AXIS_TREADY = RESETN && !fifo_full;
    assign push          = S_AXIS_TVALID && S_AXIS_TREADY;
    assign pop           = !fifo_empty && !STALL;
    assign fifo_wdata    = {S_AXIS_TLAST, S_AXIS_TDATA};
    assign at_last_idx   = (word_cnt == LAST_IDX);

    sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK    (CLK),
        .RESETN (RESETN),
        .push   (push),
        .pop    (pop),
        .wdata  (fifo_wdata),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (OCCUPANCY)
    );

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            DATA_OUT       <= '0;
            LAST_OUT       <= 1'b0;
            DATA_OUT_VALID <= 1'b0;
        end else if (pop) begin
            DATA_OUT       <= fifo_rdata[DATA_WIDTH-1:0];
            LAST_OUT       <= fifo_rdata[DATA_WIDTH];
            DATA_OUT_VALID <= 1'b1;
        end else begin
            DATA_OUT_VALID <= 1'b0;
        end
    end

    // Either TLAST or the final index closes the frame; disagreement between them is an error.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            word_cnt  <= '0;
            FRAME_ERR <= 1'b0;
        end else if (push) begin
            if (S_AXIS_TLAST || at_last_idx) begin
                word_cnt <= '0;
                if (S_AXIS_TLAST != at_last_idx)
                    FRAME_ERR <= 1'b1;
            end else begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_slave_axis_input.sv
// Self-checking bench for slave_axis_input against a queue-based reference model.
module tb_slave_axis_input;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic [31:0] S_AXIS_TDATA;
    logic        S_AXIS_TVALID;
    logic        S_AXIS_TLAST;
    logic        S_AXIS_TREADY;
    logic        STALL;
    logic [31:0] DATA_OUT;
    logic        DATA_OUT_VALID;
    logic        LAST_OUT;
    logic        FRAME_ERR;
    logic [4:0]  OCCUPANCY;

    always #5 CLK = ~CLK;

    slave_axis_input #(
        .DATA_WIDTH (32),
        .DEPTH      (16),
        .FRAME_LEN  (100)
    ) dut (
        .CLK            (CLK),
        .RESETN         (RESETN),
        .S_AXIS_TDATA   (S_AXIS_TDATA),
        .S_AXIS_TVALID  (S_AXIS_TVALID),
        .S_AXIS_TLAST   (S_AXIS_TLAST),
        .S_AXIS_TREADY  (S_AXIS_TREADY),
        .STALL          (STALL),
        .DATA_OUT       (DATA_OUT),
        .DATA_OUT_VALID (DATA_OUT_VALID),
        .LAST_OUT       (LAST_OUT),
        .FRAME_ERR      (FRAME_ERR),
        .OCCUPANCY      (OCCUPANCY)
    );

    // Reference model: queue of accepted {last,data}, words since frame start, sticky error.
    logic [32:0] mq[$];
    int          wc;
    bit          m_err;
    bit          e_valid;
    bit          e_last;
    logic [31:0] e_data;
    int          gpos;
    int          vectors;
    int          miscompares;
    logic [40:0] got;
    logic [40:0] exp;

    task automatic tick(output bit acc);
        bit          rdy;
        logic [32:0] w;
        rdy = (RESETN === 1'b1) && (mq.size() < 16);
        acc = 1'b0;
        if (RESETN !== 1'b1) begin
            mq.delete();
            wc      = 0;
            m_err   = 1'b0;
            e_valid = 1'b0;
            e_last  = 1'b0;
            e_data  = '0;
        end else begin
            if (mq.size() != 0 && !STALL) begin
                w       = mq.pop_front();
                e_valid = 1'b1;
                e_last  = w[32];
                e_data  = w[31:0];
            end else begin
                e_valid = 1'b0;
            end
            if (S_AXIS_TVALID && rdy) begin
                acc = 1'b1;
                mq.push_back({S_AXIS_TLAST, S_AXIS_TDATA});
                if (S_AXIS_TLAST || wc == 99) begin
                    if (!(S_AXIS_TLAST && wc == 99)) m_err = 1'b1;
                    wc = 0;
                end else begin
                    wc++;
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        bit acc;
        RESETN = 1'b0; S_AXIS_TVALID = 1'b1; S_AXIS_TLAST = 1'b0; S_AXIS_TDATA = 32'h1234_5678; STALL = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(acc);
            vectors++;
            if (S_AXIS_TREADY !== 1'b0 || DATA_OUT_VALID !== 1'b0 || OCCUPANCY !== 5'd0) begin
                miscompares++;
                $display("FAIL reset cyc %0d: tready=%b valid=%b occ=%0d, required 0 0 0", i, S_AXIS_TREADY, DATA_OUT_VALID, OCCUPANCY);
            end
        end
        RESETN = 1'b1; S_AXIS_TVALID = 1'b0;
        tick(acc);
        vectors++;
        got = {S_AXIS_TREADY, FRAME_ERR, OCCUPANCY, DATA_OUT_VALID, LAST_OUT, DATA_OUT};
        exp = {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0};
        if (got !== exp) begin
            miscompares++;
            $display("FAIL reset_release: got %h, required %h", got, exp);
        end
    endtask

    task automatic test_stream();
        bit acc;
        for (int i = 0; i < 130; i++) begin
            S_AXIS_TVALID = (i < 100);
            S_AXIS_TDATA  = 32'(i);
            S_AXIS_TLAST  = (i == 99);
            STALL         = 1'b0;
            tick(acc);
            if (acc) gpos++;
            vectors++;
            got = {S_AXIS_TREADY, FRAME_ERR, OCCUPANCY, DATA_OUT_VALID, LAST_OUT, DATA_OUT};
            exp = {RESETN && (mq.size() < 16), m_err, 5'(mq.size()), e_valid, e_last, e_data};
            if (got !== exp) begin
                miscompares++;
                $display("FAIL stream cyc %0d: got %h, required %h", i, got, exp);
            end
            // Word i is accepted at tick i and shown on DATA_OUT after tick i+1.
            if (i >= 1 && i <= 100) begin
                vectors++;
                if (DATA_OUT_VALID !== 1'b1 || DATA_OUT !== 32'(i - 1) || LAST_OUT !== (i == 100)) begin
                    miscompares++;
                    $display("FAIL stream_order cyc %0d: valid=%b data=%0d last=%b, required 1 %0d %b",
                             i, DATA_OUT_VALID, DATA_OUT, LAST_OUT, i - 1, i == 100);
                end
            end
        end
        vectors++;
        if (FRAME_ERR !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_err: FRAME_ERR=%b, required 0", FRAME_ERR);
        end
    endtask

    task automatic test_stall();
        bit acc;
        int idx = 0;
        int cyc = 0;
        while (!(idx == 20 && mq.size() == 0 && !e_valid && cyc > 25) && cyc < 200) begin
            S_AXIS_TVALID = (idx < 20);
            S_AXIS_TDATA  = $urandom;
            S_AXIS_TLAST  = ((gpos % 100) == 99);
            STALL         = (cyc < 25);
            tick(acc);
            if (acc) begin idx++; gpos++; end
            vectors++;
            got = {S_AXIS_TREADY, FRAME_ERR, OCCUPANCY, DATA_OUT_VALID, LAST_OUT, DATA_OUT};
            exp = {RESETN && (mq.size() < 16), m_err, 5'(mq.size()), e_valid, e_last, e_data};
            if (got !== exp) begin
                miscompares++;
                $display("FAIL stall cyc %0d: got %h, required %h", cyc, got, exp);
            end
            if (cyc == 22) begin
                vectors++;
                if (OCCUPANCY !== 5'd16 || S_AXIS_TREADY !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_full: occ=%0d tready=%b, required 16 0", OCCUPANCY, S_AXIS_TREADY);
                end
            end
            // First pop happens at the edge ending cycle 25; a slot is free right after it.
            if (cyc == 25) begin
                vectors++;
                if (S_AXIS_TREADY !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stall_ready: tready=%b, required 1", S_AXIS_TREADY);
                end
            end
            cyc++;
        end
        if (cyc >= 200) begin
            miscompares++;
            $display("FAIL stall_timeout: accepted %0d, required 20", idx);
        end
    endtask

    task automatic test_random();
        bit acc;
        int idx = 0;
        int cyc = 0;
        while (!(idx == 1000 && mq.size() == 0 && !e_valid) && cyc < 10000) begin
            S_AXIS_TVALID = (idx < 1000) && ($urandom_range(1, 100) <= 50);
            S_AXIS_TDATA  = $urandom;
            S_AXIS_TLAST  = ((gpos % 100) == 99);
            STALL         = ($urandom_range(1, 100) <= 30);
            tick(acc);
            if (acc) begin idx++; gpos++; end
            vectors++;
            got = {S_AXIS_TREADY, FRAME_ERR, OCCUPANCY, DATA_OUT_VALID, LAST_OUT, DATA_OUT};
            exp = {RESETN && (mq.size() < 16), m_err, 5'(mq.size()), e_valid, e_last, e_data};
            if (got !== exp || OCCUPANCY > 5'd16) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %h, required %h", cyc, got, exp);
            end
            cyc++;
        end
        if (cyc >= 10000) begin
            miscompares++;
            $display("FAIL random_timeout: accepted %0d, required 1000", idx);
        end
    endtask

    task automatic test_frame_err();
        bit acc;
        RESETN = 1'b0; S_AXIS_TVALID = 1'b0; STALL = 1'b0;
        tick(acc);
        RESETN = 1'b1;
        gpos   = 0;
        for (int i = 0; i < 170; i++) begin
            S_AXIS_TVALID = (i < 150);
            S_AXIS_TDATA  = $urandom;
            S_AXIS_TLAST  = (i == 49) || (i == 149);
            tick(acc);
            vectors++;
            got = {S_AXIS_TREADY, FRAME_ERR, OCCUPANCY, DATA_OUT_VALID, LAST_OUT, DATA_OUT};
            exp = {RESETN && (mq.size() < 16), m_err, 5'(mq.size()), e_valid, e_last, e_data};
            if (got !== exp) begin
                miscompares++;
                $display("FAIL frame_err cyc %0d: got %h, required %h", i, got, exp);
            end
            if (i == 48 || i == 49 || i == 169) begin
                vectors++;
                if (FRAME_ERR !== (i != 48)) begin
                    miscompares++;
                    $display("FAIL frame_err_flag cyc %0d: FRAME_ERR=%b, required %b", i, FRAME_ERR, i != 48);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        bit acc;
        RESETN = 1'b0; S_AXIS_TVALID = 1'b0; STALL = 1'b0;
        tick(acc);
        RESETN = 1'b1;
        STALL  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            S_AXIS_TVALID = 1'b1;
            S_AXIS_TDATA  = 32'hDEAD_0000 + 32'(i);
            S_AXIS_TLAST  = 1'b0;
            tick(acc);
        end
        vectors++;
        if (OCCUPANCY !== 5'd8) begin
            miscompares++;
            $display("FAIL mid_fill: occ=%0d, required 8", OCCUPANCY);
        end
        RESETN = 1'b0; S_AXIS_TVALID = 1'b0; STALL = 1'b0;
        tick(acc);
        vectors++;
        if (OCCUPANCY !== 5'd0 || DATA_OUT_VALID !== 1'b0 || FRAME_ERR !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: occ=%0d valid=%b err=%b, required 0 0 0", OCCUPANCY, DATA_OUT_VALID, FRAME_ERR);
        end
        RESETN = 1'b1;
        for (int i = 0; i < 120; i++) begin
            S_AXIS_TVALID = (i < 100);
            S_AXIS_TDATA  = 32'h5000_0000 + 32'(i);
            S_AXIS_TLAST  = (i == 99);
            tick(acc);
            vectors++;
            got = {S_AXIS_TREADY, FRAME_ERR, OCCUPANCY, DATA_OUT_VALID, LAST_OUT, DATA_OUT};
            exp = {RESETN && (mq.size() < 16), m_err, 5'(mq.size()), e_valid, e_last, e_data};
            if (got !== exp || (DATA_OUT_VALID === 1'b1 && DATA_OUT[31:16] === 16'hDEAD)) begin
                miscompares++;
                $display("FAIL mid_reset_frame cyc %0d: got %h, required %h", i, got, exp);
            end
        end
        vectors++;
        if (FRAME_ERR !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_err: FRAME_ERR=%b, required 0", FRAME_ERR);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        gpos        = 0;
        wc          = 0;
        m_err       = 1'b0;
        e_valid     = 1'b0;
        e_last      = 1'b0;
        e_data      = '0;
        test_reset();
        test_stream();
        test_stall();
        test_random();
        test_frame_err();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
